// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin select generator that
// feeds the 4:1 source mux.
package mux_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;
    // Wide enough for any MAX_HOLD in 2..255.
    localparam int unsigned HOLD_W  = 8;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    // Encoded owner index to one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_next_idx.sv
// Combinational round-robin winner search: scans from last_ptr+1 upward,
// wrapping 3->0, and reports the first requesting index.
module rr_next_idx
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   last_ptr_i,
    output logic               found_o,
    output logic [SEL_W-1:0]   idx_o
);

    // Rotating priority scan; the SEL_W-bit add wraps naturally modulo NUM_REQ.
    always_comb begin
        logic [SEL_W-1:0] cand;
        cand    = '0;
        found_o = 1'b0;
        idx_o   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = last_ptr_i + SEL_W'(k);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter producing the select for the downstream 4:1 mux.
// Outputs are registered: requests sampled at one edge appear at the next.
// Optional feature: define RR_ARB_TIMEOUT_EN to bound how long one owner
// may keep the grant (MAX_HOLD cycles) while other sources are waiting.
module rr_mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [NUM_REQ-1:0] req_in,
    output logic [NUM_REQ-1:0] grant_out,
    output logic [SEL_W-1:0]   sel_out,
    output logic               valid_out
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("rr_mux_arbiter: MAX_HOLD must be in 2..255");
    end

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_ptr_q, last_ptr_d;
`ifdef RR_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
`endif

    logic [NUM_REQ-1:0] search_req;
    logic               owner_req;
    logic               win_found;
    logic [SEL_W-1:0]   win_idx;

    // The current owner is masked out of the search, so "found" always
    // means another source is pending; in IDLE grant_q is zero and the
    // mask has no effect.
    assign search_req = req_in & ~grant_q;
    assign owner_req  = |(req_in & grant_q);

    rr_next_idx u_next_idx (
        .req_i      (search_req),
        .last_ptr_i (last_ptr_q),
        .found_o    (win_found),
        .idx_o      (win_idx)
    );

    // Next-state, grant and pointer selection.
    always_comb begin
        logic take_new;
        take_new   = 1'b0;
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        last_ptr_d = last_ptr_q;
`ifdef RR_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    take_new = 1'b1;
                end
            end
            GRANT: begin
                if (owner_req) begin
`ifdef RR_ARB_TIMEOUT_EN
                    if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
                        // At the limit: rotate if anyone waits, otherwise saturate.
                        take_new = win_found;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
`endif
                end else if (win_found) begin
                    take_new = 1'b1;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
        endcase
        if (take_new) begin
            state_d    = GRANT;
            grant_d    = idx_to_onehot(win_idx);
            sel_d      = win_idx;
            last_ptr_d = win_idx;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_d = '0;
`endif
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            last_ptr_q <= SEL_W'(NUM_REQ - 1);
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            last_ptr_q <= last_ptr_d;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign grant_out = grant_q;
    assign sel_out   = sel_q;
    assign valid_out = (state_q == GRANT);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: a table of directed vectors with
// hand-derived expectations, then a randomized run against a small model.
// Expected outputs go into a scoreboard queue as stimulus is driven and are
// popped when the registered outputs appear one edge later.
module tb_rr_mux_arbiter;
    import mux_arb_pkg::*;

    localparam int unsigned MAX_HOLD = 8;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = '0;
    logic [3:0] grant_out;
    logic [1:0] sel_out;
    logic       valid_out;

    rr_mux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .req_in    (req),
        .grant_out (grant_out),
        .sel_out   (sel_out),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       valid;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       valid;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state.
    int m_last  = 3;
    int m_sel   = 0;
    int m_hold  = 0;
    bit m_valid = 1'b0;

    function automatic void add(input string n, input logic r, input logic [3:0] q,
                                input logic [3:0] g, input logic [1:0] s, input logic v);
        vec_t x;
        x.name = n; x.rst_n = r; x.req = q; x.grant = g; x.sel = s; x.valid = v;
        vecs.push_back(x);
    endfunction

    function automatic void gr(input string n, input logic [3:0] q, input logic [1:0] s);
        logic [3:0] g;
        g = 4'b0001 << s;
        add(n, 1'b1, q, g, s, 1'b1);
    endfunction

    function automatic void id(input string n, input logic [3:0] q, input logic [1:0] s);
        add(n, 1'b1, q, 4'b0000, s, 1'b0);
    endfunction

    function automatic void rs(input string n, input logic [3:0] q);
        add(n, 1'b0, q, 4'b0000, 2'd0, 1'b0);
    endfunction

    task automatic check(input string n, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [3:0] q, input exp_t e);
        exp_t x;
        rst_n = r;
        req   = q;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            x = sb.pop_front();
            check({x.name, " grant"}, {4'b0, grant_out}, {4'b0, x.grant});
            check({x.name, " sel"},   {6'b0, sel_out},   {6'b0, x.sel});
            check({x.name, " valid"}, {7'b0, valid_out}, {7'b0, x.valid});
            check({x.name, " onehot"}, 8'($countones(grant_out) <= 1), 8'd1);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] q);
        bit keep;
        int cand;
        int idx;
        if (!r) begin
            m_valid = 1'b0; m_sel = 0; m_last = 3; m_hold = 0;
        end else begin
            keep = m_valid && q[m_sel];
            cand = -1;
            for (int k = 1; k <= 4; k++) begin
                idx = (m_last + k) % 4;
                if (cand < 0 && q[idx] && !(keep && idx == m_sel)) cand = idx;
            end
            if (keep) begin
                if (TIMEOUT && m_hold == MAX_HOLD - 1 && cand >= 0) begin
                    m_sel = cand; m_last = cand; m_hold = 0;
                end else if (m_hold < MAX_HOLD - 1) begin
                    m_hold++;
                end
            end else if (cand >= 0) begin
                m_valid = 1'b1; m_sel = cand; m_last = cand; m_hold = 0;
            end else begin
                m_valid = 1'b0; m_hold = 0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t       e;
        logic       r;
        logic [3:0] q;
        int         owner;

        // Reset overrides requests; then a quiet idle period.
        rs("rst0", 4'b1111);
        rs("rst1", 4'b1111);
        for (int i = 0; i < 5; i++) id("idle_quiet", 4'b0000, 2'd0);

        // All sources requesting, each owner briefly dropping: 0,1,2,3,0.
        gr("rr_a",  4'b1111, 2'd0);
        gr("rr_a",  4'b1111, 2'd0);
        gr("rr_b",  4'b1110, 2'd1);
        gr("rr_b",  4'b1111, 2'd1);
        gr("rr_c",  4'b1101, 2'd2);
        gr("rr_c",  4'b1111, 2'd2);
        gr("rr_d",  4'b1011, 2'd3);
        gr("rr_d",  4'b1111, 2'd3);
        gr("rr_a2", 4'b0111, 2'd0);
        id("rr_off", 4'b0000, 2'd0);

        // c pulse then d with no bubble; sel holds 3 in IDLE.
        gr("c_pulse",   4'b0100, 2'd2);
        gr("d_next",    4'b1000, 2'd3);
        gr("d_hold",    4'b1000, 2'd3);
        id("idle_sel3", 4'b0000, 2'd3);
        id("idle_sel3", 4'b0000, 2'd3);

        // Wrap 3->0 and owner holding while others wait.
        gr("wrap_a",    4'b1001, 2'd0);
        gr("d_after_a", 4'b1000, 2'd3);
        gr("d_keep",    4'b1001, 2'd3);
        id("idle2",     4'b0000, 2'd3);

        // Releasing owner gets lowest priority next.
        gr("b_first",  4'b0110, 2'd1);
        gr("c_over_a", 4'b0101, 2'd2);
        gr("a_last",   4'b0001, 2'd0);
        id("idle3",    4'b0000, 2'd0);

        // Reset mid-grant, then re-issue with request still high.
        gr("c_again",   4'b0100, 2'd2);
        rs("rst_mid",   4'b0100);
        gr("c_reissue", 4'b0100, 2'd2);
        id("idle4",     4'b0000, 2'd2);

        // Lone requester holds (hold counter saturates), then a competitor arrives.
        for (int i = 0; i < 20; i++) gr("hold_a", 4'b0001, 2'd0);
`ifdef RR_ARB_TIMEOUT_EN
        gr("sat_rotate", 4'b0011, 2'd1);
        id("idle5",      4'b0000, 2'd1);
`else
        gr("sat_keep",   4'b0011, 2'd0);
        id("idle5",      4'b0000, 2'd0);
`endif

        // Two sources held continuously.
        rs("rst_rot", 4'b0000);
        for (int c = 0; c < 24; c++) begin
`ifdef RR_ARB_TIMEOUT_EN
            owner = (c / 8) % 2;
`else
            owner = 0;
`endif
            gr("rot_ab", 4'b0011, 2'(owner));
        end
        id("idle6", 4'b0000, 2'd0);

        foreach (vecs[i]) begin
            e.name  = vecs[i].name;
            e.grant = vecs[i].grant;
            e.sel   = vecs[i].sel;
            e.valid = vecs[i].valid;
            apply(vecs[i].rst_n, vecs[i].req, e);
        end

        // Randomized traffic against the model; requests change occasionally
        // so owners are held long enough to reach the hold limit.
        q = '0;
        for (int i = 0; i < 400; i++) begin
            r = (i == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
            model_step(r, q);
            e.name  = "rand";
            e.valid = m_valid;
            e.sel   = 2'(m_sel);
            e.grant = m_valid ? (4'b0001 << m_sel) : 4'b0000;
            apply(r, q, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Purpose: upstream select generator for the 4:1 unique-case mux; owns sel_in[1:0] of that mux.

Interface
REQ-001 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-002 Parameter MAX_HOLD, 8, maximum consecutive grant cycles per owner while others wait (range 2..255).
REQ-003 Port clk_in, input, 1, rising-edge clock for all state.
REQ-004 Port rst_n_in, input, 1, synchronous active-low reset.
REQ-005 Port req_in, input, 4, request per mux source: bit0=a, bit1=b, bit2=c, bit3=d.
REQ-006 Port grant_out, output, 4, one-hot grant; all-zero when idle.
REQ-007 Port sel_out, output, 2, encoded owner index; drives the mux sel_in directly.
REQ-008 Port valid_out, output, 1, high when grant_out is non-zero and y_out is meaningful.

Function
REQ-009 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-010 IDLE->GRANT when req_in != 0; GRANT->IDLE when the owner drops its request and no other request is pending.
REQ-011 Winner search SHALL start at (last_ptr+1) mod 4 and wrap 3->0; the first set req_in bit wins.
REQ-012 Latency SHALL be one cycle: req_in sampled at edge N gives grant_out/sel_out/valid_out at edge N+1.
REQ-013 In GRANT, the owner SHALL keep the grant while its req_in bit stays high, subject to REQ-016.
REQ-014 When the owner drops its request while others are pending, the next winner SHALL be granted on the next edge with no idle bubble.
REQ-015 last_ptr SHALL update to the winner index on every new grant; a releasing owner therefore has lowest priority next.
REQ-016 hold_cnt SHALL count cycles of the current grant; when hold_cnt = MAX_HOLD-1 and another request is pending, the grant SHALL rotate on the next edge.
REQ-017 If no other request is pending at the MAX_HOLD limit, hold_cnt SHALL saturate and the owner SHALL keep the grant.
REQ-018 hold_cnt SHALL clear on every new grant and in IDLE.
REQ-019 In IDLE, sel_out SHALL hold the last granted index so the mux select is stable; grant_out = 0 and valid_out = 0.
REQ-020 grant_out SHALL always be zero or one-hot; when valid_out = 1, sel_out SHALL equal the index of the set grant_out bit.

Reset
REQ-021 While rst_n_in = 0 at an edge: state = IDLE, grant_out = 0, sel_out = 0, valid_out = 0, hold_cnt = 0, last_ptr = 3 (first search starts at 0).
REQ-022 Reset asserted mid-grant SHALL take effect at the next edge, overriding all requests; no grant is issued that cycle.

Configuration
REQ-023 Macro RR_ARB_TIMEOUT_EN: when defined, REQ-016..REQ-018 apply.
REQ-024 When RR_ARB_TIMEOUT_EN is undefined, hold_cnt SHALL NOT be synthesized; the owner holds until it drops its request, and MAX_HOLD is ignored.

Structure
REQ-025 Package mux_arb_pkg SHALL hold NUM_REQ = 4, SEL_W = 2, and the typedef enum arb_state_t {IDLE, GRANT}.
REQ-026 Sub-module rr_next_idx SHALL be purely combinational: inputs req vector and last_ptr; outputs found flag and winner index.

Verification
REQ-027 Reset, then req_in = 4'b0000 for 5 cycles -> grant_out = 0, sel_out = 0, valid_out = 0 throughout.
REQ-028 req_in = 4'b1111 held, owner drops req after 2 cycles each -> sel_out sequence 0,1,2,3,0 with no idle gap.
REQ-029 req_in = 4'b0100 pulse, then 4'b1000 -> sel_out = 2 one cycle after the first req, then 3 one cycle after c releases; in IDLE, sel_out stays 3.
REQ-030 With RR_ARB_TIMEOUT_EN and MAX_HOLD = 8, req_in = 4'b0011 held -> owner 0 granted 8 cycles, then owner 1 for 8, repeating.
REQ-031 With RR_ARB_TIMEOUT_EN and MAX_HOLD = 8, req_in = 4'b0001 held 20 cycles -> grant stays on 0 and hold_cnt saturates.
REQ-032 rst_n_in low for 1 cycle while sel_out = 2 granted -> next edge all outputs 0; after release, with req_in = 4'b0100 still high, the grant re-issues to 2 one cycle later.
